uart_msg_seq: RTL and testbench

Parametrised periodic UART message sequencer with an integrated 8N1-style transmitter. It holds a software-writable message RAM of DEPTH words and streams the first msg_len words, LSB first, on txd. Transmission is triggered by a start pulse or by an internal period tick. It sits at the top level between the configuration inputs and the uo_out[0] TX pin.

---
 rtl/uart_msg_seq_pkg.sv | 27 ++
 rtl/uart_msg_seq_tx.sv | 138 +++++++++++++
 rtl/uart_msg_seq.sv | 133 +++++++++++++
 tb/tb_uart_msg_seq.sv | 236 +++++++++++++++++++++++
 4 files changed

// File: rtl/uart_msg_seq_pkg.sv
// -----------------------------------------------------------------------------
// uart_msg_seq_pkg
// Shared types and constants for the UART message sequencer.
//   state_t          : transmitter frame state encoding
//   DEFAULT_CLK_DIV  : clocks per bit for a 10 MHz clock at 115200 baud
//   cnt_w()          : counter width helper that never returns 0
// Optional feature macro: UART_MSG_SEQ_PARITY_EN (used by the transmitter).
// -----------------------------------------------------------------------------
package uart_msg_seq_pkg;

    localparam int DEFAULT_CLK_DIV = 87;

    typedef enum logic [2:0] {
        S_IDLE,
        S_LOAD,
        S_START,
        S_DATA,
        S_PARITY,
        S_STOP
    } state_t;

    // Width of a counter that must hold 0..n-1; at least one bit.
    function automatic int cnt_w(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/uart_msg_seq_tx.sv
// -----------------------------------------------------------------------------
// uart_msg_seq_tx
// Frame transmitter: start bit, DATA_W data bits LSB first, optional even
// parity bit, stop bit; each bit lasts CLK_DIV clocks.
// Ports:
//   clk, rst       : clock, asynchronous active-high reset
//   i_load         : accept i_data and begin a frame (honoured when o_ready)
//   i_data         : word to send
//   o_ready        : transmitter idle, can accept i_load
//   o_frame_done   : one-cycle pulse in the last cycle of the stop bit
//   o_txd          : registered UART line, idle high
// Macro UART_MSG_SEQ_PARITY_EN inserts the parity bit between data and stop.
// -----------------------------------------------------------------------------
module uart_msg_seq_tx
    import uart_msg_seq_pkg::*;
#(
    parameter int CLK_DIV = DEFAULT_CLK_DIV,
    parameter int DATA_W  = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              i_load,
    input  logic [DATA_W-1:0] i_data,
    output logic              o_ready,
    output logic              o_frame_done,
    output logic              o_txd
);

    localparam int BAUD_W = cnt_w(CLK_DIV);
    localparam int BIT_W  = cnt_w(DATA_W + 1);

    state_t            r_state, w_state_next;
    logic [BAUD_W-1:0] r_baud, w_baud_next;
    logic [BIT_W-1:0]  r_bit, w_bit_next;
    logic [DATA_W-1:0] r_shift, w_shift_next;
    logic              r_txd, w_txd_next;
    logic              w_baud_last;
`ifdef UART_MSG_SEQ_PARITY_EN
    logic              r_par, w_par_next;
`endif

    assign w_baud_last  = (r_baud == BAUD_W'(CLK_DIV - 1));
    assign o_ready      = (r_state == S_IDLE);
    assign o_txd        = r_txd;

    // NOTE: every signal gets a default before the case so no path leaves it
    // unassigned; otherwise synthesis infers a latch.
    always_comb begin
        w_state_next = r_state;
        w_shift_next = r_shift;
        w_bit_next   = r_bit;
        w_baud_next  = w_baud_last ? '0 : r_baud + BAUD_W'(1);
        o_frame_done = 1'b0;
`ifdef UART_MSG_SEQ_PARITY_EN
        w_par_next   = r_par;
`endif
        case (r_state)
            S_IDLE: begin
                w_baud_next = '0;
                if (i_load) begin
                    w_state_next = S_START;
                    w_shift_next = i_data;
                    w_bit_next   = '0;
`ifdef UART_MSG_SEQ_PARITY_EN
                    w_par_next   = ^i_data;
`endif
                end
            end
            S_START: begin
                if (w_baud_last) w_state_next = S_DATA;
            end
            S_DATA: begin
                if (w_baud_last) begin
                    w_shift_next = r_shift >> 1;
                    if (r_bit == BIT_W'(DATA_W - 1)) begin
                        w_bit_next   = '0;
`ifdef UART_MSG_SEQ_PARITY_EN
                        w_state_next = S_PARITY;
`else
                        w_state_next = S_STOP;
`endif
                    end else begin
                        w_bit_next = r_bit + BIT_W'(1);
                    end
                end
            end
`ifdef UART_MSG_SEQ_PARITY_EN
            S_PARITY: begin
                if (w_baud_last) w_state_next = S_STOP;
            end
`endif
            S_STOP: begin
                if (w_baud_last) begin
                    o_frame_done = 1'b1;
                    w_state_next = S_IDLE;
                end
            end
            default: w_state_next = S_IDLE;
        endcase

        // Line level is decoded from the next state so txd comes straight
        // from a flop and cannot glitch.
        w_txd_next = 1'b1;
        case (w_state_next)
            S_START:  w_txd_next = 1'b0;
            S_DATA:   w_txd_next = w_shift_next[0];
`ifdef UART_MSG_SEQ_PARITY_EN
            S_PARITY: w_txd_next = w_par_next;
`endif
            default:  w_txd_next = 1'b1;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so every flop
    // samples pre-edge values regardless of statement order.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= S_IDLE;
            r_baud  <= '0;
            r_bit   <= '0;
            r_shift <= '0;
            r_txd   <= 1'b1;
`ifdef UART_MSG_SEQ_PARITY_EN
            r_par   <= 1'b0;
`endif
        end else begin
            r_state <= w_state_next;
            r_baud  <= w_baud_next;
            r_bit   <= w_bit_next;
            r_shift <= w_shift_next;
            r_txd   <= w_txd_next;
`ifdef UART_MSG_SEQ_PARITY_EN
            r_par   <= w_par_next;
`endif
        end
    end

endmodule

// File: rtl/uart_msg_seq.sv
// -----------------------------------------------------------------------------
// uart_msg_seq
// Periodic UART message sequencer: message RAM, period tick, trigger logic and
// word index, feeding uart_msg_seq_tx.
// Ports:
//   clk, rst          : clock, asynchronous active-high reset
//   wr_en/addr/data   : synchronous message RAM write, allowed at any time
//   msg_len           : words per message, clamped to DEPTH, sampled at trigger
//   start             : trigger, level-sampled while idle
//   auto_en           : lets the PERIOD tick trigger a message
//   txd               : UART line, idle high
//   busy              : message in progress
//   byte_done         : pulse in the last cycle of every frame
//   msg_done          : pulse in the last cycle of the final frame
//   cur_idx           : index of the word being sent
// Macro UART_MSG_SEQ_PARITY_EN adds an even parity bit to every frame.
// -----------------------------------------------------------------------------
module uart_msg_seq
    import uart_msg_seq_pkg::*;
#(
    parameter  int CLK_DIV = DEFAULT_CLK_DIV,
    parameter  int DATA_W  = 8,
    parameter  int DEPTH   = 16,
    parameter  int PERIOD  = 10000000,
    localparam int ADDR_W  = $clog2(DEPTH)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              wr_en,
    input  logic [ADDR_W-1:0] wr_addr,
    input  logic [DATA_W-1:0] wr_data,
    input  logic [ADDR_W:0]   msg_len,
    input  logic              start,
    input  logic              auto_en,
    output logic              txd,
    output logic              busy,
    output logic              byte_done,
    output logic              msg_done,
    output logic [ADDR_W-1:0] cur_idx
);

    localparam int LEN_W = ADDR_W + 1;
    localparam int PER_W = cnt_w(PERIOD);

    logic [DATA_W-1:0] r_ram [DEPTH];
    logic [PER_W-1:0]  r_period_cnt;
    logic              r_busy;
    logic              r_load;
    logic [ADDR_W-1:0] r_idx;
    logic [ADDR_W-1:0] r_last_idx;

    logic              w_per_wrap;
    logic              w_tick;
    logic              w_trig;
    logic [LEN_W-1:0]  w_len;
    logic [DATA_W-1:0] w_rdata;
    logic              w_load;
    logic              w_tx_ready;
    logic              w_frame_done;
    logic              w_last_word;

    // NOTE: the message RAM has no reset; software writes it before use, and
    // leaving it unreset lets it map onto plain memory.
    always_ff @(posedge clk) begin
        if (wr_en) r_ram[wr_addr] <= wr_data;
    end

    // Asynchronous read so a write landing before the LOAD cycle is the word
    // that gets sent.
    assign w_rdata = r_ram[r_idx];

    // Free-running period counter; PERIOD == 0 masks the tick entirely.
    assign w_per_wrap = (r_period_cnt == PER_W'(PERIOD - 1));
    assign w_tick     = (PERIOD != 0) && w_per_wrap;

    always_ff @(posedge clk or posedge rst) begin
        if (rst)             r_period_cnt <= '0;
        else if (w_per_wrap) r_period_cnt <= '0;
        else                 r_period_cnt <= r_period_cnt + PER_W'(1);
    end

    assign w_trig      = ~r_busy & (start | (w_tick & auto_en));
    assign w_len       = (msg_len > LEN_W'(DEPTH)) ? LEN_W'(DEPTH) : msg_len;
    assign w_last_word = (r_idx == r_last_idx);
    assign w_load      = r_load & w_tx_ready;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_busy     <= 1'b0;
            r_load     <= 1'b0;
            r_idx      <= '0;
            r_last_idx <= '0;
        end else begin
            // Load request holds until the transmitter takes it.
            r_load <= r_load & ~w_tx_ready;
            if (!r_busy) begin
                if (w_trig && (w_len != '0)) begin
                    r_busy     <= 1'b1;
                    r_load     <= 1'b1;
                    r_idx      <= '0;
                    r_last_idx <= ADDR_W'(w_len - LEN_W'(1));
                end
            end else if (w_frame_done) begin
                if (w_last_word) begin
                    r_busy <= 1'b0;
                    r_idx  <= '0;
                end else begin
                    r_idx  <= r_idx + ADDR_W'(1);
                    r_load <= 1'b1;
                end
            end
        end
    end

    uart_msg_seq_tx #(
        .CLK_DIV (CLK_DIV),
        .DATA_W  (DATA_W)
    ) u_tx (
        .clk          (clk),
        .rst          (rst),
        .i_load       (w_load),
        .i_data       (w_rdata),
        .o_ready      (w_tx_ready),
        .o_frame_done (w_frame_done),
        .o_txd        (txd)
    );

    assign busy      = r_busy;
    assign cur_idx   = r_idx;
    assign byte_done = w_frame_done;
    assign msg_done  = w_frame_done & w_last_word & r_busy;

endmodule

// File: tb/tb_uart_msg_seq.sv
// -----------------------------------------------------------------------------
// tb_uart_msg_seq
// Self-checking bench for uart_msg_seq with CLK_DIV=4, DATA_W=8, DEPTH=4,
// PERIOD=100. Honours UART_MSG_SEQ_PARITY_EN when it is defined.
// -----------------------------------------------------------------------------
module tb_uart_msg_seq;

`ifdef UART_MSG_SEQ_PARITY_EN
    localparam bit PAR_EN    = 1'b1;
    localparam int FRAME_CYC = 45;  // 1 LOAD + 11 bits * 4
`else
    localparam bit PAR_EN    = 1'b0;
    localparam int FRAME_CYC = 41;  // 1 LOAD + 10 bits * 4
`endif
    localparam int STOP_LO   = PAR_EN ? 41 : 37;

    localparam int EV_NONE  = 0;
    localparam int EV_START = 1;
    localparam int EV_WRITE = 2;

    typedef struct {
        logic [2:0] len_in;
        int         frames;
        int         ev;
        int         ev_cyc;
    } vec_t;

    logic       clk;
    logic       rst;
    logic       wr_en;
    logic [1:0] wr_addr;
    logic [7:0] wr_data;
    logic [2:0] msg_len;
    logic       start;
    logic       auto_en;
    logic       txd;
    logic       busy;
    logic       byte_done;
    logic       msg_done;
    logic [1:0] cur_idx;

    logic [7:0] model_ram [4];
    vec_t       vecs [7];
    int         n_checks;
    int         n_errors;

    uart_msg_seq #(
        .CLK_DIV (4),
        .DATA_W  (8),
        .DEPTH   (4),
        .PERIOD  (100)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .wr_en     (wr_en),
        .wr_addr   (wr_addr),
        .wr_data   (wr_data),
        .msg_len   (msg_len),
        .start     (start),
        .auto_en   (auto_en),
        .txd       (txd),
        .busy      (busy),
        .byte_done (byte_done),
        .msg_done  (msg_done),
        .cur_idx   (cur_idx)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    task automatic write_ram(input logic [1:0] a, input logic [7:0] d);
        @(negedge clk);
        wr_en   = 1'b1;
        wr_addr = a;
        wr_data = d;
        model_ram[a] = d;
        @(negedge clk);
        wr_en = 1'b0;
    endtask

    // Pulses start, then compares every cycle against the frame model.
    // Cycle 0 is the LOAD cycle right after the trigger edge.
    task automatic run_msg(input string name, input vec_t v);
        int   total, n_bd, n_md, n_busy, n_bad, first_bad, w, p;
        logic e_txd, e_busy, e_bd, e_md;
        logic [1:0] e_idx;
        total = v.frames * FRAME_CYC;
        n_bd = 0; n_md = 0; n_busy = 0; n_bad = 0; first_bad = -1;
        msg_len = v.len_in;
        @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        for (int c = 0; c < total + 40; c++) begin
            if (c < total) begin
                w      = c / FRAME_CYC;
                p      = c % FRAME_CYC;
                e_busy = 1'b1;
                e_idx  = w[1:0];
                e_bd   = (p == FRAME_CYC - 1);
                e_md   = e_bd && (w == v.frames - 1);
                if (p == 0)                  e_txd = 1'b1;
                else if (p <= 4)             e_txd = 1'b0;
                else if (p <= 36)            e_txd = model_ram[w][(p - 5) / 4];
                else if (p < STOP_LO)        e_txd = ^model_ram[w];
                else                         e_txd = 1'b1;
            end else begin
                e_busy = 1'b0; e_idx = 2'd0; e_bd = 1'b0; e_md = 1'b0; e_txd = 1'b1;
            end
            if ({txd, busy, byte_done, msg_done, cur_idx} !== {e_txd, e_busy, e_bd, e_md, e_idx}) begin
                n_bad++;
                if (first_bad < 0) first_bad = c;
            end
            n_bd   += int'(byte_done);
            n_md   += int'(msg_done);
            n_busy += int'(busy);
            start = (v.ev == EV_START) && (c == v.ev_cyc);
            wr_en = (v.ev == EV_WRITE) && (c == v.ev_cyc);
            if (wr_en) begin
                wr_addr = 2'd1;
                wr_data = 8'hA5;
                model_ram[1] = 8'hA5;
            end
            @(negedge clk);
        end
        start = 1'b0;
        wr_en = 1'b0;
        check({name, " byte_done count"}, n_bd, v.frames);
        check({name, " msg_done count"}, n_md, (v.frames > 0) ? 1 : 0);
        check({name, " busy cycles"}, n_busy, total);
        check({name, " waveform cycles differing"}, n_bad, 0);
        if (n_bad != 0) $display("  %s first difference at cycle %0d", name, first_bad);
    endtask

    initial begin
        int n_rise, rise1, rise2, fall1, n_busy;
        logic prev;
        n_checks = 0;
        n_errors = 0;
        rst = 1'b1; wr_en = 1'b0; wr_addr = '0; wr_data = '0;
        msg_len = '0; start = 1'b0; auto_en = 1'b0;

        vecs[0] = '{3'd2, 2, EV_NONE,  0};   // two words, 82 busy cycles
        vecs[1] = '{3'd1, 1, EV_NONE,  0};
        vecs[2] = '{3'd4, 4, EV_NONE,  0};   // full RAM
        vecs[3] = '{3'd7, 4, EV_NONE,  0};   // clamped to DEPTH
        vecs[4] = '{3'd0, 0, EV_NONE,  0};   // empty message: nothing
        vecs[5] = '{3'd2, 2, EV_START, 20};  // start while busy is dropped
        vecs[6] = '{3'd2, 2, EV_WRITE, 10};  // word 1 rewritten before its LOAD

        // Reset state
        repeat (3) @(negedge clk);
        check("reset txd", txd, 1);
        check("reset busy", busy, 0);
        check("reset byte_done", byte_done, 0);
        check("reset msg_done", msg_done, 0);
        check("reset cur_idx", cur_idx, 0);
        rst = 1'b0;

        write_ram(2'd0, 8'h48);
        write_ram(2'd1, 8'h69);
        write_ram(2'd2, 8'h3C);
        write_ram(2'd3, 8'hC3);

        for (int i = 0; i < 7; i++) run_msg($sformatf("row%0d", i), vecs[i]);

        // Auto trigger: frames every 100 cycles, 59 idle cycles between.
        msg_len = 3'd1;
        auto_en = 1'b1;
        n_rise = 0; rise1 = -1; rise2 = -1; fall1 = -1; prev = 1'b0;
        for (int c = 0; c < 400; c++) begin
            @(negedge clk);
            if (busy && !prev) begin
                n_rise++;
                if (rise1 < 0) rise1 = c;
                else if (rise2 < 0) rise2 = c;
            end
            if (!busy && prev && fall1 < 0) fall1 = c;
            prev = busy;
        end
        auto_en = 1'b0;
        check("auto at least 3 frames", (n_rise >= 3) ? 1 : 0, 1);
        check("auto tick spacing", rise2 - rise1, 100);
        check("auto idle gap", rise2 - fall1, 100 - FRAME_CYC);
        for (int c = 0; c < 60 && busy; c++) @(negedge clk);
        check("auto drains", busy, 0);
        n_busy = 0;
        for (int c = 0; c < 150; c++) begin
            @(negedge clk);
            n_busy += int'(busy);
        end
        check("auto disabled quiet", n_busy, 0);

        // Reset in the DATA state of word 1.
        msg_len = 3'd2;
        @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (FRAME_CYC + 9) @(negedge clk);
        check("pre-reset busy", busy, 1);
        check("pre-reset cur_idx", cur_idx, 1);
        rst = 1'b1;
        #1;
        check("mid-reset txd", txd, 1);
        check("mid-reset busy", busy, 0);
        check("mid-reset byte_done", byte_done, 0);
        check("mid-reset msg_done", msg_done, 0);
        @(negedge clk);
        rst = 1'b0;
        run_msg("after reset", '{3'd1, 1, EV_NONE, 0});

        if (PAR_EN) begin
            write_ram(2'd0, 8'h49);
            run_msg("parity odd data", '{3'd1, 1, EV_NONE, 0});
        end

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
